// File: rtl/uart_wb_cmd_ctrl.sv
// uart_wb_cmd_ctrl: parses ASCII hex command frames from a UART byte stream,
// runs one Wishbone master cycle per frame and sends the ASCII response back.
module uart_wb_cmd_ctrl #(
    parameter int WB_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_busy,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [15:0] o_wb_adr,
    output logic [7:0]  o_wb_dat,
    input  logic [7:0]  i_wb_dat,
    input  logic        i_wb_ack,
    output logic        o_rx_drop
);
    localparam int TW = $clog2(WB_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SYNC_A, ADDR, CMD, WDATA, WB, RESP} state_t;

    state_t        state_q, state_d;
    logic [15:0]   adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic          we_q, we_d;
    logic [1:0]    acnt_q, acnt_d;
    logic          dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cyc_q, cyc_d;
    logic [15:0]   resp_q, resp_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic          txv_q, txv_d;
    logic [7:0]    txd_q, txd_d;
    logic          skip_q, skip_d;
    logic [4:0]    hx;
    logic          err;
    logic          parsing;

    // {valid, nibble}; letters of either case have low nibble 1..6, so +9 maps them to A..F
    function automatic logic [4:0] hex_dec(input logic [7:0] c);
        logic dig, let_c;
        dig   = c >= 8'h30 && c <= 8'h39;
        let_c = (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
        return {dig | let_c, dig ? c[3:0] : c[3:0] + 4'd9};
    endfunction

    function automatic logic [7:0] hex_enc(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    assign parsing = state_q == SYNC_A || state_q == ADDR || state_q == CMD || state_q == WDATA;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        tcnt_d  = tcnt_q;
        cyc_d   = cyc_q;
        resp_d  = resp_q;
        rcnt_d  = rcnt_q;
        txv_d   = 1'b0;
        txd_d   = txd_q;
        skip_d  = skip_q;
        err     = 1'b0;
        hx      = hex_dec(i_rx_data);
        case (state_q)
            IDLE: begin
                if (i_rx_valid && i_rx_data == 8'h00) state_d = SYNC_A;
            end
            SYNC_A: begin
                if (i_rx_valid) begin
                    if (i_rx_data == "A") state_d = ADDR;
                    else err = 1'b1;
                end
            end
            ADDR: begin
                if (i_rx_valid) begin
                    if (hx[4]) begin
                        adr_d  = {adr_q[11:0], hx[3:0]};
                        acnt_d = acnt_q + 2'd1;
                        if (acnt_q == 2'd3) state_d = CMD;
                    end else err = 1'b1;
                end
            end
            CMD: begin
                if (i_rx_valid) begin
                    if (i_rx_data == "W") state_d = WDATA;
                    else if (i_rx_data == "R") begin
                        state_d = WB;
                        we_d    = 1'b0;
                    end else err = 1'b1;
                end
            end
            WDATA: begin
                if (i_rx_valid) begin
                    if (hx[4]) begin
                        dat_d  = {dat_q[3:0], hx[3:0]};
                        dcnt_d = ~dcnt_q;
                        if (dcnt_q) begin
                            state_d = WB;
                            we_d    = 1'b1;
                        end
                    end else err = 1'b1;
                end
            end
            WB: begin
                // ack is checked before the timeout, so an ack in the final cycle wins
                if (!cyc_q) begin
                    cyc_d  = 1'b1;
                    tcnt_d = '0;
                end else if (i_wb_ack) begin
                    cyc_d   = 1'b0;
                    state_d = RESP;
                    resp_d  = we_q ? {"K", 8'h00} : {hex_enc(i_wb_dat[7:4]), hex_enc(i_wb_dat[3:0])};
                    rcnt_d  = we_q ? 2'd1 : 2'd2;
                end else if (tcnt_q == T_LAST) begin
                    cyc_d   = 1'b0;
                    state_d = RESP;
                    resp_d  = {"T", 8'h00};
                    rcnt_d  = 2'd1;
                end else tcnt_d = tcnt_q + TW'(1);
            end
            RESP: begin
                // busy is ignored for one cycle after a strobe while the UART picks it up
                if (txv_q) begin
                    if (rcnt_q == 2'd0) state_d = IDLE;
                    else skip_d = 1'b1;
                end else if (skip_q) skip_d = 1'b0;
                else if (!i_tx_busy) begin
                    txv_d  = 1'b1;
                    txd_d  = resp_q[15:8];
                    resp_d = {resp_q[7:0], 8'h00};
                    rcnt_d = rcnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_rx_valid && i_rx_data == 8'h00 && (parsing || state_q == IDLE)) begin
            state_d = SYNC_A;
            acnt_d  = 2'd0;
            dcnt_d  = 1'b0;
        end else if (err) begin
            state_d = RESP;
            resp_d  = {"?", 8'h00};
            rcnt_d  = 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            acnt_q  <= '0;
            dcnt_q  <= 1'b0;
            tcnt_q  <= '0;
            cyc_q   <= 1'b0;
            resp_q  <= '0;
            rcnt_q  <= '0;
            txv_q   <= 1'b0;
            txd_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
            tcnt_q  <= tcnt_d;
            cyc_q   <= cyc_d;
            resp_q  <= resp_d;
            rcnt_q  <= rcnt_d;
            txv_q   <= txv_d;
            txd_q   <= txd_d;
            skip_q  <= skip_d;
        end
    end

    assign o_tx_data  = txd_q;
    assign o_tx_valid = txv_q;
    assign o_wb_cyc   = cyc_q;
    assign o_wb_stb   = cyc_q;
    assign o_wb_we    = we_q;
    assign o_wb_adr   = adr_q;
    assign o_wb_dat   = dat_q;
    assign o_rx_drop  = !i_reset && i_rx_valid && (state_q == WB || state_q == RESP);
endmodule

// File: tb/tb_uart_wb_cmd_ctrl.sv
// tb_uart_wb_cmd_ctrl: directed frames against a scoreboard of expected
// Wishbone cycles and transmitted bytes, with a simple slave and UART model.
module tb_uart_wb_cmd_ctrl;
    localparam int TO = 20;

    typedef struct {
        logic        we;
        logic [15:0] adr;
        logic [7:0]  dat;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr;
    logic [7:0]  wb_dat_o;
    logic [7:0]  rdata;
    logic        wb_ack = 1'b0;
    logic        rx_drop;

    int checks = 0;
    int errors = 0;
    int ack_delay, busy_len, busy_cnt = 0;
    int cyc_len = 0, last_cyc_len = 0, rx_age = 0, drop_cnt = 0, d0;
    logic cyc_prev = 1'b0;
    logic [15:0] cur_adr;
    wb_t exp_wb[$];
    logic [7:0] exp_tx[$];

    uart_wb_cmd_ctrl #(.WB_TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_busy(tx_busy),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat_o), .i_wb_dat(rdata), .i_wb_ack(wb_ack), .o_rx_drop(rx_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #2;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic push_wb(input logic we, input logic [15:0] adr, input logic [7:0] dat);
        wb_t e;
        e.we = we; e.adr = adr; e.dat = dat;
        exp_wb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk); #2;
            done = exp_tx.size() == 0 && exp_wb.size() == 0 && !wb_cyc;
        end
        check(tag, done, 1'b1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc();
        for (int i = 0; i < 50 && !wb_cyc; i++) begin
            @(posedge clk); #2;
        end
        check("cyc_wait", wb_cyc, 1'b1);
    endtask

    // Monitor: Wishbone slave, UART busy model and scoreboard checks
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            rx_age = rx_valid ? 0 : rx_age + 1;
            if (rx_drop) drop_cnt++;
            if (wb_cyc && !cyc_prev) begin
                check("wb_latency", rx_age, 2);
                check("wb_stb", wb_stb, 1'b1);
                check("wb_pending", exp_wb.size() != 0, 1'b1);
                if (exp_wb.size() != 0) begin
                    e = exp_wb.pop_front();
                    check("wb_adr", wb_adr, e.adr);
                    check("wb_we", wb_we, e.we);
                    if (e.we) check("wb_dat", wb_dat_o, e.dat);
                end
                cyc_len = 0;
                cur_adr = wb_adr;
            end
            if (wb_cyc) begin
                cyc_len++;
                check("wb_adr_stable", wb_adr, cur_adr);
            end
            if (!wb_cyc && cyc_prev) last_cyc_len = cyc_len;
            wb_ack   = wb_cyc && ack_delay != 0 && cyc_len == ack_delay;
            cyc_prev = wb_cyc;
            if (tx_valid) begin
                check("tx_busy_clear", tx_busy, 1'b0);
                check("tx_pending", exp_tx.size() != 0, 1'b1);
                if (exp_tx.size() != 0) check("tx_data", tx_data, exp_tx.pop_front());
                tx_busy  = 1'b1;
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
        ack_delay = 3; busy_len = 3; rdata = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cyc", wb_cyc, 1'b0);
        check("rst_stb", wb_stb, 1'b0);
        check("rst_we", wb_we, 1'b0);
        check("rst_adr", wb_adr, 16'h0);
        check("rst_dat", wb_dat_o, 8'h0);
        check("rst_txv", tx_valid, 1'b0);
        check("rst_txd", tx_data, 8'h0);
        check("rst_drop", rx_drop, 1'b0);
        rx_valid = 1'b0; rst = 1'b0;

        // write, preceded by a junk byte that IDLE must ignore
        send_byte(8'h55);
        push_wb(1'b1, 16'h3410, 8'h5C); exp_tx.push_back("K");
        send_byte(8'h00); send_str("A3410W5C");
        wait_idle("write_done");

        // read: two response bytes, each gated by busy
        busy_len = 6; rdata = 8'hA7;
        push_wb(1'b0, 16'h3410, 8'h00); exp_tx.push_back("A"); exp_tx.push_back("7");
        send_byte(8'h00); send_str("A3410R");
        wait_idle("read_done");

        // bad digit -> '?', no bus cycle
        exp_tx.push_back("?");
        send_byte(8'h00); send_str("A1x");
        wait_idle("err_done");

        // 0x00 mid-frame restarts parsing
        rdata = 8'h3C;
        push_wb(1'b0, 16'hFFFF, 8'h00); exp_tx.push_back("3"); exp_tx.push_back("C");
        send_byte(8'h00); send_str("A1"); send_byte(8'h00); send_str("AffffR");
        wait_idle("resync_done");

        // no ack -> timeout after exactly TO cycles
        ack_delay = 0;
        push_wb(1'b0, 16'h1234, 8'h00); exp_tx.push_back("T");
        send_byte(8'h00); send_str("A1234R");
        wait_idle("timeout_done");
        check("timeout_len", last_cyc_len, TO);

        // ack in the final timeout cycle is a success
        ack_delay = TO; rdata = 8'h5E;
        push_wb(1'b0, 16'h0FA0, 8'h00); exp_tx.push_back("5"); exp_tx.push_back("E");
        send_byte(8'h00); send_str("A0fA0R");
        wait_idle("late_ack_done");
        check("late_ack_len", last_cyc_len, TO);

        // byte (0x00) injected during WB is dropped
        ack_delay = 6; d0 = drop_cnt;
        push_wb(1'b1, 16'h00C0, 8'h12); exp_tx.push_back("K");
        send_byte(8'h00); send_str("A00C0W12");
        wait_cyc();
        send_byte(8'h00);
        wait_idle("drop_done");
        check("drop_count", drop_cnt - d0, 1);

        // reset during WB: cycle aborted, nothing sent
        ack_delay = 0;
        push_wb(1'b0, 16'hBEEF, 8'h00);
        send_byte(8'h00); send_str("ABEEFR");
        wait_cyc();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        check("rstwb_cyc", wb_cyc, 1'b0);
        check("rstwb_stb", wb_stb, 1'b0);
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        ack_delay = 2;
        push_wb(1'b1, 16'h00AB, 8'hFF); exp_tx.push_back("K");
        send_byte(8'h00); send_str("A00abWff");
        wait_idle("after_rst_done");

        // reset during RESP: second byte never sent
        busy_len = 15; ack_delay = 1; rdata = 8'h91;
        push_wb(1'b0, 16'h0042, 8'h00); exp_tx.push_back("9");
        send_byte(8'h00); send_str("A0042R");
        wait_idle("resp_first_done");
        rst = 1'b1;
        @(posedge clk); #2;
        check("rstresp_txv", tx_valid, 1'b0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("rstresp_txv_end", tx_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_wb_cmd_ctrl.md
UART_WB_CMD_CTRL -- requirements
Module: uart_wb_cmd_ctrl

Interface
REQ-001 Parameter WB_TIMEOUT, default 255, is the maximum number of cycles to wait for i_wb_ack before a cycle is aborted.
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 i_clk  in  1  system clock; all logic on rising edge.
REQ-004 i_reset  in  1  synchronous active-high reset.
REQ-005 i_rx_data  in  8  received UART byte.
REQ-006 i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-007 o_tx_data  out  8  byte to transmit.
REQ-008 o_tx_valid  out  1  one-cycle transmit request strobe.
REQ-009 i_tx_busy  in  1  UART transmitter busy.
REQ-010 o_wb_cyc, o_wb_stb  out  1 each  Wishbone master cycle and strobe.
REQ-011 o_wb_we  out  1  Wishbone write enable.
REQ-012 o_wb_adr  out  16  Wishbone address.
REQ-013 o_wb_dat  out  8  Wishbone write data.
REQ-014 i_wb_dat  in  8  Wishbone read data.
REQ-015 i_wb_ack  in  1  Wishbone acknowledge.
REQ-016 o_rx_drop  out  1  one-cycle pulse when a received byte is discarded.

Function
REQ-017 Command frames SHALL be:
- write: 0x00, 'A', 4 hex address digits (MSB first), 'W', 2 hex data digits (MSB first);
- read: 0x00, 'A', 4 hex address digits, 'R'.
REQ-018 Hex digits SHALL be '0'-'9', 'A'-'F' and 'a'-'f'; each digit shifts into the address or data register 4 bits at a time, with the first digit landing in the MSBs.
REQ-019 FSM states SHALL be IDLE, SYNC_A, ADDR, CMD, WDATA, WB, RESP.
- IDLE: only 0x00 advances, to SYNC_A; all other bytes are ignored silently.
- SYNC_A: 'A' advances to ADDR.
- ADDR: after the 4th hex digit, advances to CMD.
- CMD: 'W' goes to WDATA; 'R' goes to WB with we=0.
- WDATA: after the 2nd hex digit, goes to WB with we=1.
REQ-020 In SYNC_A, ADDR, CMD or WDATA, a byte of 0x00 SHALL restart parsing at SYNC_A and clear the digit counters.
REQ-021 In SYNC_A, ADDR, CMD or WDATA, any other unexpected byte SHALL queue a response of '?' and go to RESP.
REQ-022 WB timing:
- on entry, o_wb_cyc=o_wb_stb=1 on the next cycle;
- adr, dat and we stay stable until the cycle ends;
- cyc and stb drop in the cycle after i_wb_ack is sampled high.
REQ-023 Read capture: i_wb_dat SHALL be captured in the ack cycle.
REQ-024 WB SHALL end in the same cycle the timeout counter reaches WB_TIMEOUT without ack.
- Abort: cyc and stb drop, response 'T'.
- An ack arriving in the timeout cycle counts as success.
REQ-025 Responses SHALL be:
- write OK: 'K';
- read OK: 2 uppercase ASCII hex chars of the read data, high nibble first;
- error: '?';
- timeout: 'T'.
REQ-026 RESP transmit handshake, per byte:
- wait for i_tx_busy=0, then pulse o_tx_valid for 1 cycle with o_tx_data held;
- ignore i_tx_busy for the next cycle;
- then wait for busy=0 before the next byte.
REQ-027 After the last response byte is handed off, the FSM SHALL return to IDLE.
REQ-028 Bytes arriving (i_rx_valid=1) in WB or RESP SHALL be discarded with o_rx_drop=1 in the same cycle; this includes 0x00.
REQ-029 Latency SHALL be: o_wb_cyc rises 2 cycles after the i_rx_valid of the final frame byte (1 cycle to enter WB, 1 to assert).
REQ-030 The digit counters SHALL be 2-bit (ADDR) and 1-bit (WDATA), and the timeout counter SHALL be wide enough for WB_TIMEOUT.

Reset
REQ-031 While i_reset=1, the FSM SHALL be in IDLE, all outputs 0, address, data and counters cleared, and any pending response discarded.
REQ-032 Reset asserted during WB SHALL drop o_wb_cyc and o_wb_stb at the next clock edge with no response sent.
REQ-033 Reset asserted during RESP SHALL drop o_tx_valid at the next clock edge, and no further bytes are sent.
REQ-034 The first byte accepted after reset deassertion SHALL be a byte arriving on or after the first cycle with i_reset=0.

Verification
REQ-035 Write: 00 'A' '3' '4' '1' '0' 'W' '5' 'C' -> one WB write with adr=0x3410, dat=0x5C, we=1; ack after 3 cycles -> tx 'K'.
REQ-036 Read: 00 'A' '3' '4' '1' '0' 'R', slave returns 0xA7 -> WB read with adr=0x3410, we=0 -> tx 'A' then '7', the second strobe only after busy is deasserted.
REQ-037 Error and resync:
- 00 'A' '1' 'x' -> tx '?', no WB cycle;
- 00 'A' '1' 00 'A' 'f' 'f' 'f' 'f' 'R' -> read at adr=0xFFFF.
REQ-038 Timeout: valid read frame with the ack tied low -> cyc held exactly WB_TIMEOUT cycles, then tx 'T', FSM back in IDLE.
REQ-039 Drop: byte injected during WB -> o_rx_drop pulse, frame result unchanged.
REQ-040 Reset mid-cycle: i_reset during WB -> cyc=stb=0 next edge, no tx, and a following valid frame executes normally.
